// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - control/status bundle between control_unit and the datapath
interface control_unit_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [3:0] alu_flags;
    logic       pc_we;
    logic       ir_we;
    logic       rf_we;
    logic       d_mem_we;
    logic [3:0] alu_cmd;
    logic       alu_src;
    logic       pc_src;
    logic       rf_src;
    logic       halted;

    modport master (
        input  opcode,
        input  funct3,
        input  alu_flags,
        output pc_we,
        output ir_we,
        output rf_we,
        output d_mem_we,
        output alu_cmd,
        output alu_src,
        output pc_src,
        output rf_src,
        output halted
    );

    modport slave (
        output opcode,
        output funct3,
        output alu_flags,
        input  pc_we,
        input  ir_we,
        input  rf_we,
        input  d_mem_we,
        input  alu_cmd,
        input  alu_src,
        input  pc_src,
        input  rf_src,
        input  halted
    );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle RV64 control FSM driving datapath strobes and selects
module control_unit #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    control_unit_if.master cu
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [2:0] C_R      = 3'd0;
    localparam logic [2:0] C_IALU   = 3'd1;
    localparam logic [2:0] C_LOAD   = 3'd2;
    localparam logic [2:0] C_STORE  = 3'd3;
    localparam logic [2:0] C_BRANCH = 3'd4;
    localparam logic [2:0] C_LUI    = 3'd5;
    localparam logic [2:0] C_JAL    = 3'd6;
    localparam logic [2:0] C_ILL    = 3'd7;

    localparam logic [3:0] MEM_INIT = 4'(MEM_LAT - 1);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [2:0] cls;
    logic [2:0] dec_cls;
    logic [2:0] f3;
    logic [3:0] mem_cnt;
    logic       halted_q;
    logic       taken;
    logic       in_body;

    always_comb begin
        dec_cls = C_ILL;
        case (cu.opcode)
            7'b0110011: dec_cls = C_R;
            7'b0010011: dec_cls = C_IALU;
            7'b0000011: dec_cls = C_LOAD;
            7'b0100011: dec_cls = C_STORE;
            7'b1100011: dec_cls = C_BRANCH;
            7'b0110111: dec_cls = C_LUI;
            7'b1101111: dec_cls = C_JAL;
            default:    dec_cls = C_ILL;
        endcase
    end

    // Signed compare uses MSB^ovf of A-B; unsigned uses carry-out (1 = no borrow).
    always_comb begin
        taken = 1'b0;
        case (f3)
            3'b000:  taken = cu.alu_flags[0];
            3'b001:  taken = ~cu.alu_flags[0];
            3'b100:  taken = cu.alu_flags[1] ^ cu.alu_flags[2];
            3'b101:  taken = ~(cu.alu_flags[1] ^ cu.alu_flags[2]);
            3'b110:  taken = ~cu.alu_flags[3];
            3'b111:  taken = cu.alu_flags[3];
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = (dec_cls == C_ILL) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (cls == C_LOAD || cls == C_STORE)
                    state_nxt = S_MEM;
                else if (cls == C_BRANCH)
                    state_nxt = S_FETCH;
                else
                    state_nxt = S_WB;
            end
            S_MEM: begin
                if (mem_cnt == 4'd0)
                    state_nxt = (cls == C_LOAD) ? S_WB : S_FETCH;
                else
                    state_nxt = S_MEM;
            end
            S_WB:     state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            cls      <= C_R;
            f3       <= 3'd0;
            mem_cnt  <= 4'd0;
            halted_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) begin
                cls <= dec_cls;
                f3  <= cu.funct3;
            end
            if (state == S_EXEC)
                mem_cnt <= MEM_INIT;
            else if (state == S_MEM && mem_cnt != 4'd0)
                mem_cnt <= mem_cnt - 4'd1;
            if (state_nxt == S_HALT)
                halted_q <= 1'b1;
        end
    end

    assign in_body = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);

    always_comb begin
        cu.pc_we    = 1'b0;
        cu.ir_we    = 1'b0;
        cu.rf_we    = 1'b0;
        cu.d_mem_we = 1'b0;
        cu.alu_cmd  = 4'b0000;
        cu.alu_src  = 1'b0;
        cu.pc_src   = 1'b0;
        cu.rf_src   = 1'b0;
        cu.halted   = halted_q;

        if (in_body) begin
            case (cls)
                C_R:      cu.alu_cmd = 4'b0000;
                C_IALU:   cu.alu_cmd = 4'b0001;
                C_LOAD:   cu.alu_cmd = 4'b0001;
                C_STORE:  cu.alu_cmd = 4'b0010;
                C_BRANCH: cu.alu_cmd = 4'b0011;
                C_LUI:    cu.alu_cmd = 4'b0100;
                C_JAL:    cu.alu_cmd = 4'b0101;
                default:  cu.alu_cmd = 4'b0000;
            endcase
            cu.alu_src = ~((cls == C_R) || (cls == C_BRANCH));
        end

        case (state)
            S_FETCH: cu.ir_we = 1'b1;
            S_EXEC: begin
                if (cls == C_BRANCH) begin
                    cu.pc_we  = 1'b1;
                    cu.pc_src = taken;
                end
            end
            S_MEM: begin
                // Store strobe is a one-cycle pulse on the first MEM cycle only.
                if (cls == C_STORE) begin
                    cu.d_mem_we = (mem_cnt == MEM_INIT);
                    cu.pc_we    = (mem_cnt == 4'd0);
                end
            end
            S_WB: begin
                cu.rf_we  = 1'b1;
                cu.pc_we  = 1'b1;
                cu.rf_src = (cls == C_LOAD);
                cu.pc_src = (cls == C_JAL);
            end
            default: ;
        endcase
    end
endmodule
